// File: rtl/control_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface   : control_sequencer_if                                     |
// | Description : Datapath-facing bundle of the hardwired control unit:    |
// |               status inputs (IR, CON_FF, MemReady, Stop) and all       |
// |               control strobes, ALU op code, Run and MemErr.            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface control_sequencer_if;
  logic        Stop;
  logic [31:0] IR;
  logic        CON_FF;
  logic        MemReady;

  logic        PCout, PCin, IncPC;
  logic        MARin, MDRin, MDRout;
  logic        Read, Write;
  logic        IRin, Yin, Zin;
  logic        Zlowout, ZHighout;
  logic        HIout, LOout, HIin, LOin;
  logic        Cout, InPortout;
  logic        GRA, GRB, GRC, Rin, Rout, BAout;
  logic        CONin;
  logic [4:0]  operation;
  logic        Run;
  logic        MemErr;

  // Sequencer side
  modport master (
    input  Stop, IR, CON_FF, MemReady,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write,
           IRin, Yin, Zin, Zlowout, ZHighout, HIout, LOout, HIin, LOin,
           Cout, InPortout, GRA, GRB, GRC, Rin, Rout, BAout, CONin,
           operation, Run, MemErr
  );

  // Datapath / memory side
  modport slave (
    output Stop, IR, CON_FF, MemReady,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write,
           IRin, Yin, Zin, Zlowout, ZHighout, HIout, LOout, HIin, LOin,
           Cout, InPortout, GRA, GRB, GRC, Rin, Rout, BAout, CONin,
           operation, Run, MemErr
  );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : control_sequencer                                        |
// | Description : Hardwired control unit. Fetch T0-T2, decode IR[31:27],   |
// |               execute T3-T7, memory wait states with timeout, halt.    |
// |               Optional macro CTRL_MULDIV_EN decodes mul/div.           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module control_sequencer #(
  parameter logic [4:0]  OP_ADD = 5'b00011,
  parameter int unsigned MEM_TO = 8
) (
  input wire                  clk,
  input wire                  rst,
  control_sequencer_if.master bus
);

  localparam int CNT_W = (MEM_TO < 2) ? 1 : $clog2(MEM_TO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TO > 0) ? MEM_TO - 1 : 0);

  // T-states share their step number in the low bits so the execute
  // sequencer can compare against the instruction's final step directly.
  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_RST = 4'd8, S_HALT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_HALT, C_R, C_I, C_LD, C_ST, C_BR,
    C_JR, C_JAL, C_MFHI, C_MFLO, C_MD
  } cls_t;

  state_t           state, nxt;
  cls_t             cls;
  logic [2:0]       last_step;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err, mem_busy, timeout;
  logic             unused_ir;

  assign unused_ir  = ^bus.IR[26:0];
  assign bus.Run    = (state != S_RST) && (state != S_HALT);
  assign bus.MemErr = mem_err;

  // Instruction class and final execute step from the opcode field
  always_comb begin
    cls = C_NOP;
    case (bus.IR[31:27])
      5'b00011, 5'b00100, 5'b00101, 5'b00110: cls = C_R;
      5'b01100, 5'b01101, 5'b01110:           cls = C_I;
      5'b00000: cls = C_LD;
      5'b00010: cls = C_ST;
      5'b10010: cls = C_BR;
      5'b10011: cls = C_JR;
      5'b10100: cls = C_JAL;
      5'b10110: cls = C_MFHI;
      5'b10111: cls = C_MFLO;
      5'b11011: cls = C_HALT;
`ifdef CTRL_MULDIV_EN
      5'b01111, 5'b10000: cls = C_MD;
`endif
      default:  cls = C_NOP;
    endcase
    case (cls)
      C_R, C_I:              last_step = 3'd5;
      C_LD, C_ST:            last_step = 3'd7;
      C_BR, C_MD:            last_step = 3'd6;
      C_JR, C_MFHI, C_MFLO:  last_step = 3'd3;
      C_JAL:                 last_step = 3'd4;
      default:               last_step = 3'd2;
    endcase
  end

  // Moore strobe decode from the state register and the held IR
  always_comb begin
    bus.PCout = 1'b0; bus.PCin = 1'b0; bus.IncPC = 1'b0;
    bus.MARin = 1'b0; bus.MDRin = 1'b0; bus.MDRout = 1'b0;
    bus.Read = 1'b0; bus.Write = 1'b0;
    bus.IRin = 1'b0; bus.Yin = 1'b0; bus.Zin = 1'b0;
    bus.Zlowout = 1'b0; bus.ZHighout = 1'b0;
    bus.HIout = 1'b0; bus.LOout = 1'b0; bus.HIin = 1'b0; bus.LOin = 1'b0;
    bus.Cout = 1'b0; bus.InPortout = 1'b0;
    bus.GRA = 1'b0; bus.GRB = 1'b0; bus.GRC = 1'b0;
    bus.Rin = 1'b0; bus.Rout = 1'b0; bus.BAout = 1'b0; bus.CONin = 1'b0;
    bus.operation = 5'b00000;
    case (state)
      S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
      S_T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
      S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      S_T3: case (cls)
        C_R, C_I:   begin bus.GRB = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
        C_LD, C_ST: begin bus.GRB = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
        C_BR:       begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
        C_JR:       begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
        C_JAL:      begin bus.PCout = 1'b1; bus.GRB = 1'b1; bus.Rin = 1'b1; end
        C_MFHI:     begin bus.HIout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; end
        C_MFLO:     begin bus.LOout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; end
        C_MD:       begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
        default: ;
      endcase
      S_T4: case (cls)
        C_R:        begin bus.GRC = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.operation = bus.IR[31:27]; end
        C_I:        begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.operation = bus.IR[31:27]; end
        C_LD, C_ST: begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.operation = OP_ADD; end
        C_BR:       begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
        C_JAL:      begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
        C_MD:       begin bus.GRB = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.operation = bus.IR[31:27]; end
        default: ;
      endcase
      S_T5: case (cls)
        C_R, C_I:   begin bus.Zlowout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; end
        C_LD, C_ST: begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
        C_BR:       begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.operation = OP_ADD; end
`ifdef CTRL_MULDIV_EN
        C_MD:       begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
`endif
        default: ;
      endcase
      S_T6: case (cls)
        C_LD:       begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
        C_ST:       begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
        C_BR:       begin bus.Zlowout = 1'b1; bus.PCin = bus.CON_FF; end
`ifdef CTRL_MULDIV_EN
        C_MD:       begin bus.ZHighout = 1'b1; bus.HIin = 1'b1; end
`endif
        default: ;
      endcase
      S_T7: case (cls)
        C_LD:       begin bus.MDRout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; end
        C_ST:       bus.Write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

  // Next state: memory stall/timeout first, then fetch/execute sequencing
  always_comb begin
    nxt      = state;
    timeout  = 1'b0;
    mem_busy = (bus.Read | bus.Write) & ~bus.MemReady;
    if (mem_busy) begin
      if ((MEM_TO != 0) && (wait_cnt == CNT_LAST)) begin
        nxt     = S_HALT;
        timeout = 1'b1;
      end
    end else begin
      case (state)
        S_RST:      nxt = S_T0;
        S_HALT:     nxt = S_HALT;
        S_T0, S_T1: nxt = state_t'(state + 4'd1);
        S_T2: begin
          if (cls == C_HALT)          nxt = S_HALT;
          else if (last_step == 3'd2) nxt = bus.Stop ? S_HALT : S_T0;
          else                        nxt = S_T3;
        end
        default: begin
          if (state[2:0] == last_step) nxt = bus.Stop ? S_HALT : S_T0;
          else                         nxt = state_t'(state + 4'd1);
        end
      endcase
    end
  end

  // State, wait counter and sticky memory-error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RST;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state <= nxt;
      if (timeout) mem_err <= 1'b1;
      if (mem_busy && !timeout) wait_cnt <= wait_cnt + CNT_W'(1);
      else                      wait_cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_control_sequencer                                     |
// | Description : Self-checking bench: per-opcode step table expanded into |
// |               an expected per-cycle strobe stream, plus literal probes.|
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_control_sequencer;
  localparam int         MEM_TO = 8;
  localparam logic [4:0] OP_ADD = 5'b00011;

  localparam logic [32:0] PCOUT = 33'h1 << 0,  PCIN  = 33'h1 << 1,  INCPC = 33'h1 << 2;
  localparam logic [32:0] MARIN = 33'h1 << 3,  MDRIN = 33'h1 << 4,  MDROUT = 33'h1 << 5;
  localparam logic [32:0] READ  = 33'h1 << 6,  WRITE = 33'h1 << 7,  IRIN  = 33'h1 << 8;
  localparam logic [32:0] YIN   = 33'h1 << 9,  ZIN   = 33'h1 << 10, ZLO   = 33'h1 << 11;
  localparam logic [32:0] ZHI   = 33'h1 << 12, HIOUT = 33'h1 << 13, LOOUT = 33'h1 << 14;
  localparam logic [32:0] HIIN  = 33'h1 << 15, LOIN  = 33'h1 << 16, COUT  = 33'h1 << 17;
  localparam logic [32:0] GRA   = 33'h1 << 19, GRB   = 33'h1 << 20, GRC   = 33'h1 << 21;
  localparam logic [32:0] RIN   = 33'h1 << 22, ROUT  = 33'h1 << 23, BAOUT = 33'h1 << 24;
  localparam logic [32:0] CONIN = 33'h1 << 25, MEMERR = 33'h1 << 31, RUN = 33'h1 << 32;

  typedef struct packed { logic [32:0] v; logic mr; } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_sequencer_if bus();
  control_sequencer #(.OP_ADD(OP_ADD), .MEM_TO(MEM_TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [32:0] dut_vec;
  assign dut_vec = {bus.Run, bus.MemErr, bus.operation, bus.CONin, bus.BAout, bus.Rout, bus.Rin,
                    bus.GRC, bus.GRB, bus.GRA, bus.InPortout, bus.Cout, bus.LOin, bus.HIin,
                    bus.LOout, bus.HIout, bus.ZHighout, bus.Zlowout, bus.Zin, bus.Yin, bus.IRin,
                    bus.Write, bus.Read, bus.MDRout, bus.MDRin, bus.MARin, bus.IncPC, bus.PCin,
                    bus.PCout};

  // Model: execute-step table per opcode (length 0 = behaves as nop)
  logic [32:0] prog_step [32][5];
  int          prog_len  [32];
  ent_t        q[$];
  logic        dead;

  logic [32:0] exp_vec = '0, lit_val = '0;
  logic        chk_en = 1'b0, lit_en = 1'b0;
  string       lit_name = "";
  int          n_chk = 0, n_pass = 0;

  function automatic logic [32:0] opv(input logic [4:0] o);
    return {2'b00, o, 26'd0};
  endfunction

  task automatic def(input logic [4:0] op, input int n,
                     input logic [32:0] a, b, c, d, e);
    prog_len[op] = n;
    prog_step[op][0] = a; prog_step[op][1] = b; prog_step[op][2] = c;
    prog_step[op][3] = d; prog_step[op][4] = e;
  endtask

  task automatic halt_tail(input logic [32:0] v);
    q.push_back({v, 1'b1});
    q.push_back({v, 1'b1});
  endtask

  // A memory step repeats while MemReady is low; too long a wait ends in HALT with MemErr
  task automatic push_mem(input logic [32:0] v, input int w);
    if (MEM_TO != 0 && w >= MEM_TO) begin
      for (int k = 0; k < MEM_TO; k++) q.push_back({v, 1'b0});
      dead = 1'b1;
      halt_tail(MEMERR);
    end else begin
      for (int k = 0; k < w; k++) q.push_back({v, 1'b0});
      q.push_back({v, 1'b1});
    end
  endtask

  task automatic run_instr(input logic [4:0] op, input logic con, input logic stp,
                           input int fw, input int ew, input int probe_idx,
                           input logic [32:0] probe_val, input string pname,
                           input int abort_idx);
    logic [32:0] v;
    q.delete();
    dead = 1'b0;
    q.push_back({RUN | PCOUT | MARIN | INCPC | ZIN, 1'b1});
    push_mem(RUN | ZLO | PCIN | READ | MDRIN, fw);
    if (!dead) begin
      q.push_back({RUN | MDROUT | IRIN, 1'b1});
      if (op == 5'b11011) halt_tail('0);
      else begin
        for (int k = 0; k < prog_len[op]; k++) begin
          v = prog_step[op][k] | RUN;
          if (op == 5'b10010 && k == 3 && con) v = v | PCIN;
          if ((v & (READ | WRITE)) != '0) push_mem(v, ew);
          else q.push_back({v, 1'b1});
          if (dead) break;
        end
        if (!dead && stp) halt_tail('0);
      end
    end
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        bus.IR = {op, 4'd5, 4'd2, 4'd3, 15'd0};
        bus.Stop = stp;
        bus.CON_FF = con;
      end
      bus.MemReady = q[i].mr;
      exp_vec  = q[i].v;
      lit_en   = (i == probe_idx);
      lit_val  = probe_val;
      lit_name = pname;
      if (i == abort_idx) begin
        rst = 1'b1;
        exp_vec = '0;
        lit_en = 1'b1; lit_val = '0; lit_name = "abort_reset";
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; exp_vec = '0; lit_en = 1'b0;
    bus.Stop = 1'b0; bus.MemReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
  endtask

  // Single compare process: model stream every cycle, literal probe when armed
  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (dut_vec === exp_vec) n_pass++;
      else $display("FAIL model t=%0t: dut=%h expected=%h", $time, dut_vec, exp_vec);
      if (lit_en) begin
        n_chk++;
        if (dut_vec === lit_val) n_pass++;
        else $display("FAIL %s t=%0t: dut=%h expected=%h", lit_name, $time, dut_vec, lit_val);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.Stop = 1'b0; bus.IR = '0; bus.CON_FF = 1'b0; bus.MemReady = 1'b1;
    for (int o = 0; o < 32; o++) prog_len[o] = 0;
    foreach (prog_step[a, b]) prog_step[a][b] = '0;
    for (int o = 3; o <= 6; o++)
      def(5'(o), 3, GRB | ROUT | YIN, GRC | ROUT | ZIN | opv(5'(o)), ZLO | GRA | RIN, '0, '0);
    for (int o = 12; o <= 14; o++)
      def(5'(o), 3, GRB | ROUT | YIN, COUT | ZIN | opv(5'(o)), ZLO | GRA | RIN, '0, '0);
    def(5'b00000, 5, GRB | BAOUT | YIN, COUT | ZIN | opv(OP_ADD), ZLO | MARIN,
        READ | MDRIN, MDROUT | GRA | RIN);
    def(5'b00010, 5, GRB | BAOUT | YIN, COUT | ZIN | opv(OP_ADD), ZLO | MARIN,
        GRA | ROUT | MDRIN, WRITE);
    def(5'b10010, 4, GRA | ROUT | CONIN, PCOUT | YIN, COUT | ZIN | opv(OP_ADD), ZLO, '0);
    def(5'b10011, 1, GRA | ROUT | PCIN, '0, '0, '0, '0);
    def(5'b10100, 2, PCOUT | GRB | RIN, GRA | ROUT | PCIN, '0, '0, '0);
    def(5'b10110, 1, HIOUT | GRA | RIN, '0, '0, '0, '0);
    def(5'b10111, 1, LOOUT | GRA | RIN, '0, '0, '0, '0);
`ifdef CTRL_MULDIV_EN
    for (int o = 15; o <= 16; o++)
      def(5'(o), 4, GRA | ROUT | YIN, GRB | ROUT | ZIN | opv(5'(o)), ZLO | LOIN, ZHI | HIIN, '0);
`endif

    // Reset state
    @(posedge clk); #1;
    exp_vec = '0; lit_en = 1'b1; lit_val = '0; lit_name = "reset_state"; chk_en = 1'b1;
    @(posedge clk); #1 lit_en = 1'b0;
    @(negedge clk); #1 rst = 1'b0;

    run_instr(5'b10011, 0, 0, 0, 0, 3, 33'h1_0088_0002, "jr_T3", -1);
    run_instr(5'b00011, 0, 0, 0, 0, 4, 33'h1_0CA0_0400, "add_T4", -1);
    run_instr(5'b01101, 0, 0, 0, 0, -1, '0, "", -1);
    run_instr(5'b00000, 0, 0, 0, 3, 9, 33'h1_0000_0050, "ld_wait_last", -1);
    run_instr(5'b00010, 0, 0, 1, 2, -1, '0, "", -1);
    run_instr(5'b10010, 0, 0, 0, 0, -1, '0, "", -1);
    run_instr(5'b10010, 1, 0, 0, 0, 6, 33'h1_0000_0802, "br_taken_T6", -1);
    run_instr(5'b10100, 0, 0, 0, 0, -1, '0, "", -1);
    run_instr(5'b10110, 0, 0, 0, 0, -1, '0, "", -1);
    run_instr(5'b10111, 0, 0, 0, 0, -1, '0, "", -1);
    run_instr(5'b11010, 0, 0, 0, 0, -1, '0, "", -1);
    run_instr(5'b01111, 0, 0, 0, 0, -1, '0, "", -1);
    run_instr(5'b00100, 0, 1, 0, 0, -1, '0, "", -1);
    do_reset();
    run_instr(5'b11011, 0, 0, 0, 0, 3, 33'h0, "halt_op", -1);
    do_reset();
    run_instr(5'b00000, 0, 0, 0, 0, -1, '0, "", 5);
    @(negedge clk); #1 rst = 1'b0;
    run_instr(5'b11010, 0, 0, 20, 0, 9, 33'h0_8000_0000, "timeout_halt", -1);
    do_reset();
    run_instr(5'b00110, 0, 0, 0, 0, -1, '0, "", -1);

    @(posedge clk); #1 chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
